// File: rtl/table_port_arbiter.sv
// Round-robin arbiter sharing one 256x8 table port among NUM_REQ cores (IDLE -> ACCESS -> DONE).
// Optional burst locking is enabled by defining TABLE_ARB_LOCK_EN.
module table_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                           state, nextState;
  logic [IDX_W-1:0]                 ptr, owner, arbIdx, selIdx;
  logic [NUM_REQ-1:0]               ownerOh, arbMask;
  logic                             arbValid, arbGo, contGo, weLatch;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   addrArr;
  logic [NUM_REQ-1:0][DATA_W-1:0]   wdataArr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : gSlice
    assign addrArr[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdataArr[i] = wdata[i*DATA_W +: DATA_W];
  end

  always_comb begin
    ownerOh        = '0;
    ownerOh[owner] = 1'b1;
  end

  // The owner finishing in DONE is masked so it cannot be granted twice in a row by arbitration.
  assign arbMask = req & ~((state == DONE) ? ownerOh : '0);

  always_comb begin
    logic [IDX_W-1:0] idx;
    arbValid = 1'b0;
    arbIdx   = ptr;
    idx      = ptr;
    // Descending scan so the candidate closest to ptr is the last (winning) assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (arbMask[idx]) begin
        arbValid = 1'b1;
        arbIdx   = idx;
      end
    end
  end

`ifdef TABLE_ARB_LOCK_EN
  logic [3:0] burstCnt;
  logic       unusedLock;
  assign unusedLock = 1'b0;
  assign contGo = (state == DONE) && lock[owner] && req[owner] &&
                  (burstCnt < 4'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      burstCnt <= '0;
    else if (arbGo) burstCnt <= '0;
    else if (contGo) burstCnt <= burstCnt + 4'd1;
  end
`else
  logic unusedLock;
  assign unusedLock = ^lock;
  assign contGo     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and arbitration decision
  always_comb begin
    nextState = state;
    arbGo     = 1'b0;
    case (state)
      IDLE: begin
        if (arbValid) begin
          arbGo     = 1'b1;
          nextState = ACCESS;
        end
      end
      ACCESS: nextState = DONE;
      DONE: begin
        if (contGo) begin
          nextState = ACCESS;
        end else if (arbValid) begin
          arbGo     = 1'b1;
          nextState = ACCESS;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign selIdx = arbGo ? arbIdx : owner;

  // Request fields are captured only when a new access is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      owner     <= '0;
      weLatch   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (arbGo) begin
        owner <= arbIdx;
        ptr   <= arbIdx + IDX_W'(1);
      end
      if (arbGo || contGo) begin
        weLatch   <= we[selIdx];
        mem_addr  <= addrArr[selIdx];
        mem_wdata <= wdataArr[selIdx];
      end
      if (state == ACCESS) rdata <= mem_rdata;
    end
  end

  // Outputs decode from state, so an asynchronous reset drops them immediately.
  always_comb begin
    gnt    = (state != IDLE)   ? ownerOh : '0;
    ack    = (state == DONE)   ? ownerOh : '0;
    mem_we = (state == ACCESS) && weLatch;
  end

endmodule

// File: tb/tb_table_port_arbiter.sv
// Directed bench for table_port_arbiter: stimulus pushes expected acks into a scoreboard,
// an independent negedge monitor pops and compares whenever ack is asserted.
module tb_table_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req, lock, we, gnt, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;

  logic [7:0] tbMem [256];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int core; logic [7:0] data;} exp_t;
  exp_t sbq[$];

  table_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mem_rdata = tbMem[mem_addr];
  always @(posedge clk) if (mem_we) tbMem[mem_addr] <= mem_wdata;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(int c, logic [7:0] a, logic w, logic [7:0] d);
    req[c]            = 1'b1;
    we[c]             = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic pushExp(int c, logic [7:0] d);
    exp_t e;
    e.core = c;
    e.data = d;
    sbq.push_back(e);
  endtask

  // Waits (bounded) for the next ack pulse and checks it belongs to core c.
  task automatic waitAck(int c, bit dropReq, output int at);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (ack != '0) break;
    end
    check($sformatf("ack_core%0d", c), {28'b0, ack}, 32'd1 << c);
    at = cyc;
    if (dropReq) begin
      req[c] = 1'b0;
      we[c]  = 1'b0;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ack != '0) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_ack: got=%0h want=none", ack);
      end else begin
        e = sbq.pop_front();
        check("sb_ack", {28'b0, ack}, 32'd1 << e.core);
        check("sb_rdata", {24'b0, rdata}, {24'b0, e.data});
      end
    end
  end

  initial begin
    int t, tPrev, tIssue;
    int ord[$];
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) tbMem[i] = 8'(i);

    repeat (3) @(negedge clk);
    check("rst_gnt", {28'b0, gnt}, 0);
    check("rst_ack", {28'b0, ack}, 0);
    check("rst_rdata", {24'b0, rdata}, 0);
    check("rst_mem_addr", {24'b0, mem_addr}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_wdata", {24'b0, mem_wdata}, 0);
    reset = 1'b0;

    // Single read by core 2
    @(negedge clk);
    issue(2, 8'h35, 1'b0, 8'h00);
    pushExp(2, 8'h35);
    tIssue = cyc;
    @(negedge clk);
    check("rd_gnt_access", {28'b0, gnt}, 32'h4);
    check("rd_mem_addr", {24'b0, mem_addr}, 32'h35);
    check("rd_mem_we", {31'b0, mem_we}, 0);
    waitAck(2, 1'b1, t);
    check("rd_latency", t - tIssue, 2);
    check("rd_gnt_done", {28'b0, gnt}, 32'h4);
    @(negedge clk);
    check("rd_gnt_idle", {28'b0, gnt}, 0);

    // Full contention from ptr=3 after the read; re-sync with a known order from ptr=3
    // Core 2 won last, so ptr=3: expected order 3,0,1,2.
    for (int i = 0; i < N; i++) begin
      issue(i, 8'(8'h40 + i), 1'b0, 8'h00);
    end
    ord = '{3, 0, 1, 2};
    foreach (ord[k]) pushExp(ord[k], 8'(8'h40 + ord[k]));
    tPrev = 0;
    foreach (ord[k]) begin
      waitAck(ord[k], 1'b1, t);
      if (k > 0) check("cont_spacing", t - tPrev, 2);
      tPrev = t;
    end
    @(negedge clk);
    check("cont_idle_gnt", {28'b0, gnt}, 0);

    // Reset, then the 0,1,2,3 contention case from ptr=0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      issue(i, 8'(8'h40 + i), 1'b0, 8'h00);
      pushExp(i, 8'(8'h40 + i));
    end
    for (int i = 0; i < N; i++) begin
      waitAck(i, 1'b1, t);
      if (i > 0) check("cont0_spacing", t - tPrev, 2);
      tPrev = t;
    end
    @(negedge clk);
    // ptr must have wrapped to 0: core 0 beats core 3
    issue(0, 8'h50, 1'b0, 8'h00);
    issue(3, 8'h53, 1'b0, 8'h00);
    pushExp(0, 8'h50);
    pushExp(3, 8'h53);
    waitAck(0, 1'b1, t);
    waitAck(3, 1'b1, t);

    // Write then read back
    @(negedge clk);
    issue(1, 8'h10, 1'b1, 8'hA5);
    pushExp(1, 8'h10);
    @(negedge clk);
    check("wr_mem_we", {31'b0, mem_we}, 1);
    check("wr_mem_addr", {24'b0, mem_addr}, 32'h10);
    check("wr_mem_wdata", {24'b0, mem_wdata}, 32'hA5);
    check("wr_gnt", {28'b0, gnt}, 32'h2);
    waitAck(1, 1'b1, t);
    check("wr_we_done", {31'b0, mem_we}, 0);
    @(negedge clk);
    issue(3, 8'h10, 1'b0, 8'h00);
    pushExp(3, 8'hA5);
    waitAck(3, 1'b1, t);

    // Lock burst: core 0 locked, core 1 waiting
    @(negedge clk);
    issue(0, 8'h20, 1'b0, 8'h00);
    lock[0] = 1'b1;
    issue(1, 8'h21, 1'b0, 8'h00);
`ifdef TABLE_ARB_LOCK_EN
    ord = '{0, 0, 0, 0, 1};
`else
    ord = '{0, 1, 0, 1};
`endif
    foreach (ord[k]) pushExp(ord[k], 8'(8'h20 + ord[k]));
    foreach (ord[k]) waitAck(ord[k], 1'b0, t);
    req = '0;
    lock = '0;
    @(negedge clk);

    // Reset during a write's ACCESS cycle
    @(negedge clk);
    issue(2, 8'h30, 1'b1, 8'h55);
    @(negedge clk);
    check("rst_mid_we_pre", {31'b0, mem_we}, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_we", {31'b0, mem_we}, 0);
    check("rst_mid_gnt", {28'b0, gnt}, 0);
    check("rst_mid_ack", {28'b0, ack}, 0);
    check("rst_mid_addr", {24'b0, mem_addr}, 0);
    req = '0;
    we = '0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_table", {24'b0, tbMem[8'h30]}, 32'h30);
    issue(3, 8'h31, 1'b0, 8'h00);
    pushExp(3, 8'h31);
    tIssue = cyc;
    @(negedge clk);
    check("post_rst_gnt", {28'b0, gnt}, 32'h8);
    waitAck(3, 1'b1, t);
    check("post_rst_latency", t - tIssue, 2);

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/table_port_arbiter.md
# table_port_arbiter

Round-robin arbiter that shares the single access port of a 256x8 lookup table among up to NUM_REQ processor cores. Each core raises a request carrying address, write-enable and write data. The arbiter serialises these requests onto the table port. It returns read data plus a one-cycle acknowledge to the winning core. It sits between the core cluster and the table storage, so each core needs no private read port.

## Interface
- NUM_REQ, 4: number of requesters; power of two, 2..8.
- ADDR_W, 8: table address width.
- DATA_W, 8: table data width.
- MAX_BURST, 4: maximum consecutive locked accesses per owner; range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset; one clock; reset is asynchronous and active-high.
- req  in  NUM_REQ  per-core request; held high through its ack cycle.
- lock  in  NUM_REQ  per-core burst-hold request; used only with TABLE_ARB_LOCK_EN.
- we  in  NUM_REQ  per-core write enable, qualified by req.
- addr  in  NUM_REQ*ADDR_W  flattened addresses; core i uses [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened write data; same slicing as addr.
- gnt  out  NUM_REQ  one-hot grant; high for the owner during ACCESS and DONE.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  registered read data; valid while ack is high.
- mem_addr  out  ADDR_W  address to the table port.
- mem_we  out  1  table write strobe.
- mem_wdata  out  DATA_W  table write data.
- mem_rdata  in  DATA_W  table read data; combinational from mem_addr.

## Operation
- FSM states:
  - IDLE: if any req is high, arbitrate, latch the winner's addr, we and wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_addr is the latched address and mem_we is the latched write enable. On the exit edge, capture mem_rdata into rdata, then go to DONE.
  - DONE: ack[owner]=1.
    - If a lock continuation applies, go directly to ACCESS for the same owner, re-latching the new addr, we and wdata.
    - Else if any non-owner req is high, arbitrate and go to ACCESS.
    - Else go to IDLE.
- Arbitration: scan from pointer ptr upward, modulo NUM_REQ. The first asserted req wins. On each arbitration win by core i, ptr becomes (i+1) mod NUM_REQ.
- In DONE, the current owner's req is masked from arbitration. It is finishing its access and cannot double-grant.
- Request fields are sampled only on the arbitration edge. They may change afterwards.
- Write access: mem_we is high for exactly the one ACCESS cycle. rdata on a write returns the pre-write table contents.
- mem_addr and mem_wdata hold their last latched value outside ACCESS. mem_we is 0 outside ACCESS.
- Reset values: state=IDLE, ptr=0, burst count=0, gnt=0, ack=0, rdata=0, mem_addr=0, mem_we=0, mem_wdata=0.
- Reset asserted mid-operation: all outputs go to their reset values immediately. mem_we drops asynchronously, so no partial write is committed on a later edge. The in-flight access is discarded without an ack.

## Timing
- Edge E0 samples req in IDLE. gnt goes high after E0. rdata and ack are valid between E1 and E2.
- Request-to-ack latency is 2 edges.
- Back-to-back throughput is 1 access per 2 cycles (ACCESS/DONE alternate).
- If req is dropped before the arbitration edge, that core is not granted. Dropping req after the grant does not abort the access.

## Configuration
- TABLE_ARB_LOCK_EN defined:
  - In DONE, if lock[owner]=1, req[owner]=1 and burst count < MAX_BURST-1, the owner is re-granted without arbitration and the burst count increments.
  - The burst count clears on every arbitration win.
  - ptr is updated only on arbitration wins.
- TABLE_ARB_LOCK_EN undefined: the lock input is ignored and the burst counter is not synthesised. Every DONE arbitrates normally.

## Test plan
- Single read: table holds identity (Data[n]=n); req[2]=1, addr2=0x35 -> gnt[2] high 2 cycles; ack[2] pulses 2 edges after sampling; rdata=0x35.
- Contention: after reset, req[3:0]=4'b1111 held until each ack -> acks in order 0,1,2,3, one every 2 cycles; ptr ends at 0.
- Write then read: core1 writes 0xA5 to 0x10 -> mem_we high 1 cycle with mem_addr=0x10, mem_wdata=0xA5; core1 rdata=0x10 (pre-write value); a subsequent core3 read of 0x10 returns 0xA5.
- Lock burst, MAX_BURST=4, req0 with lock0=1 and req1 waiting: with TABLE_ARB_LOCK_EN, four consecutive acks to core0 precede core1's ack; without the macro, acks alternate 0,1,0,1.
- Reset asserted during a write's ACCESS cycle -> mem_we, gnt and ack drop to 0 immediately and the table is unchanged; after release, a lone req[3] is granted from IDLE with normal latency.
